// File: rtl/uwasic_spi_pwm_periph_if.sv
// Pad-side bundle of the Tiny Tapeout user tile: dedicated inputs, bidir inputs,
// and the three output buses. The tile drives the slave side; the harness the master.
interface uwasic_spi_pwm_periph_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/uwasic_spi_pwm_periph.sv
// SPI write-only register bank driving 16 static/PWM output channels.
// ui_in[0]=SCLK, ui_in[1]=COPI, ui_in[2]=nCS; SPI mode 0, 16-bit frames:
// {write, addr[6:0], data[7:0]}. Optional macro PWM_ALIGN_EN: duty writes go
// to a shadow register that loads into the active duty at the phase wrap.
module uwasic_spi_pwm_periph #(
  parameter int unsigned PWM_PRESCALE = 13,
  parameter int unsigned NUM_REGS     = 5
) (
  input logic                    clk,
  input logic                    rst,
  uwasic_spi_pwm_periph_if.slave pads
);

  localparam int unsigned     PreW      = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax    = PreW'(PWM_PRESCALE - 1);
  localparam logic [6:0]      AddrLimit = 7'(NUM_REGS);

  // ena, uio_in and the spare ui_in bits carry no function in this tile
  logic unused_pads;
  assign unused_pads = ^{pads.ena, pads.uio_in, pads.ui_in[7:3]};

  // Synchronizers; the third stage of SCLK/nCS exists only for edge detection
  logic [2:0] sclk_q, ncs_q;
  logic [1:0] copi_q;

  // Two-flop synchronizers plus edge-detect history
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      copi_q <= '0;
      ncs_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], pads.ui_in[0]};
      copi_q <= {copi_q[0], pads.ui_in[1]};
      ncs_q  <= {ncs_q[1:0], pads.ui_in[2]};
    end
  end

  logic sclk_rise, ncs_fall, ncs_rise, selected;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign ncs_fall  = ncs_q[2] & ~ncs_q[1];
  assign ncs_rise  = ncs_q[1] & ~ncs_q[2];
  assign selected  = ~ncs_q[1];

  logic [15:0] shift_q, shift_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        commit_q, commit_d;
  logic [6:0]  waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        frame_ok;

  // Bit count saturates so over-long frames never alias back to 16
  assign frame_ok = (cnt_q == 5'd16) && shift_q[15] && (shift_q[14:8] < AddrLimit);

  // SPI shift/count next state and commit capture on nCS release
  always_comb begin
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    commit_d = ncs_rise & frame_ok;
    waddr_d  = ncs_rise ? shift_q[14:8] : waddr_q;
    wdata_d  = ncs_rise ? shift_q[7:0] : wdata_q;
    if (ncs_fall) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (sclk_rise && selected) begin
      shift_d = {shift_q[14:0], copi_q[1]};
      if (cnt_q != 5'd31) begin
        cnt_d = cnt_q + 5'd1;
      end
    end
  end

  // SPI state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      commit_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  logic [15:0] en_out_q, en_pwm_q;
  logic [7:0]  duty_q;
  logic [PreW-1:0] pre_q, pre_d;
  logic [7:0]  phase_q, phase_d;
  logic        pre_wrap;

  assign pre_wrap = (pre_q == PreMax);

`ifdef PWM_ALIGN_EN
  logic [7:0] duty_shadow_q;

  // Register bank write, one clk after the nCS rising edge is seen
  always_ff @(posedge clk) begin
    if (rst) begin
      en_out_q      <= '0;
      en_pwm_q      <= '0;
      duty_shadow_q <= '0;
    end else if (commit_q) begin
      case (waddr_q)
        7'd0:    en_out_q[7:0]  <= wdata_q;
        7'd1:    en_out_q[15:8] <= wdata_q;
        7'd2:    en_pwm_q[7:0]  <= wdata_q;
        7'd3:    en_pwm_q[15:8] <= wdata_q;
        7'd4:    duty_shadow_q  <= wdata_q;
        default: ;
      endcase
    end
  end

  // Active duty only changes at the 255->0 phase wrap so no period is cut short
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
    end else if (pre_wrap && (phase_q == 8'hFF)) begin
      duty_q <= duty_shadow_q;
    end
  end
`else
  // Register bank write, one clk after the nCS rising edge is seen
  always_ff @(posedge clk) begin
    if (rst) begin
      en_out_q <= '0;
      en_pwm_q <= '0;
      duty_q   <= '0;
    end else if (commit_q) begin
      case (waddr_q)
        7'd0:    en_out_q[7:0]  <= wdata_q;
        7'd1:    en_out_q[15:8] <= wdata_q;
        7'd2:    en_pwm_q[7:0]  <= wdata_q;
        7'd3:    en_pwm_q[15:8] <= wdata_q;
        7'd4:    duty_q         <= wdata_q;
        default: ;
      endcase
    end
  end
`endif

  logic        pwm;
  logic [15:0] out_q, out_d;

  // Prescaler/phase next state and channel gating
  always_comb begin
    pre_d   = pre_wrap ? '0 : pre_q + 1'b1;
    phase_d = pre_wrap ? phase_q + 8'd1 : phase_q;
    pwm     = (duty_q == 8'hFF) | (phase_q < duty_q);
    out_d   = en_out_q & (~en_pwm_q | {16{pwm}});
  end

  // PWM counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      phase_q <= '0;
      out_q   <= '0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
      out_q   <= out_d;
    end
  end

  assign pads.uo_out  = out_q[7:0];
  assign pads.uio_out = out_q[15:8];
  assign pads.uio_oe  = 8'hFF;

endmodule

// File: tb/tb_uwasic_spi_pwm_periph.sv
// Self-checking bench for uwasic_spi_pwm_periph (default build, duty applied at once).
// A cycle-indexed model derives every output from the programmed registers and the
// number of clocks since reset; directed checks pin it with literal values.
`timescale 1ns/1ps
module tb_uwasic_spi_pwm_periph;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  uwasic_spi_pwm_periph_if pads ();

  uwasic_spi_pwm_periph dut (
    .clk  (clk),
    .rst  (rst),
    .pads (pads)
  );

  // Clocks since the last reset edge
  int n = 0;
  always @(posedge clk) n <= rst ? 0 : n + 1;

  // Model state
  logic [15:0] m_en_out = '0;
  logic [15:0] m_en_pwm = '0;
  logic [7:0]  m_duty   = '0;
  int          mark_n   = -100;
  int          total    = 0;
  int          passed   = 0;

  // Output after k clocks: registered gating of phase floor((k-1)/13) mod 256
  function automatic logic [15:0] expect_out(input int k);
    int   ph;
    logic p;
    if (k <= 0) return 16'h0000;
    ph = ((k - 1) / 13) % 256;
    p  = (m_duty == 8'hFF) || (ph < int'(m_duty));
    return m_en_out & (~m_en_pwm | {16{p}});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act >= lo && act <= hi) passed++;
    else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic clocks(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic model_commit(input logic [31:0] word, input int nbits);
    if (nbits == 16 && word[15] && word[14:8] < 7'd5) begin
      case (word[10:8])
        3'd0: m_en_out[7:0]  = word[7:0];
        3'd1: m_en_out[15:8] = word[7:0];
        3'd2: m_en_pwm[7:0]  = word[7:0];
        3'd3: m_en_pwm[15:8] = word[7:0];
        default: m_duty      = word[7:0];
      endcase
    end
  endtask

  // Shift nbits of word MSB first; optionally release nCS and update the model
  task automatic spi_frame(input logic [31:0] word, input int nbits, input bit finish);
    pads.ui_in[2] = 1'b0;
    clocks(4);
    for (int i = 0; i < nbits; i++) begin
      pads.ui_in[1] = word[nbits-1-i];
      clocks(4);
      pads.ui_in[0] = 1'b1;
      clocks(4);
      pads.ui_in[0] = 1'b0;
    end
    clocks(4);
    if (finish) begin
      pads.ui_in[2] = 1'b1;
      mark_n = n;
      model_commit(word, nbits);
      clocks(12);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pads.ui_in = 8'h04;
    m_en_out = '0;
    m_en_pwm = '0;
    m_duty   = '0;
    mark_n   = -100;
    clocks(5);
    rst = 1'b0;
  endtask

  task automatic wait_level(input logic lvl, output int at_n, output realtime at_t);
    bit ok = 1'b0;
    at_n = 0;
    at_t = 0.0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (pads.uo_out[0] === lvl) begin
        at_n = n;
        at_t = $realtime;
        ok   = 1'b1;
      end else begin
        clocks(1);
      end
    end
    check("pwm_edge_seen", {31'd0, ok}, 32'd1);
  endtask

  int      n0, n1, n2, cnt, kind, nb;
  realtime t0, t1, t2;
  logic [31:0] w;

  initial begin
    pads.ena    = 1'b1;
    pads.uio_in = 8'h00;
    pads.ui_in  = 8'h04;
    do_reset();

    check("reset_uo_out", {24'd0, pads.uo_out}, 32'h00);
    check("reset_uio_out", {24'd0, pads.uio_out}, 32'h00);
    check("reset_uio_oe", {24'd0, pads.uio_oe}, 32'hFF);

    // Model compare on every cycle outside the commit latency window
    fork
      forever begin
        @(negedge clk);
        if (!rst && n >= mark_n + 8)
          check("model_out", {8'd0, pads.uio_oe, pads.uio_out, pads.uo_out},
                {8'd0, 8'hFF, expect_out(n)});
      end
    join_none

    // Static outputs
    spi_frame(32'h80F0, 16, 1);
    spi_frame(32'h8101, 16, 1);
    check("static_uo_out", {24'd0, pads.uo_out}, 32'hF0);
    check("static_uio_out", {24'd0, pads.uio_out}, 32'h01);
    clocks(50);
    check("static_hold", {16'd0, pads.uio_out, pads.uo_out}, 32'h01F0);

    // Invalid frames: read, bad address, short, long
    spi_frame(32'h00AA, 16, 1);
    spi_frame(32'hB0FF, 16, 1);
    spi_frame(32'h402A, 15, 1);
    spi_frame(32'h10001, 17, 1);
    check("invalid_uo_out", {24'd0, pads.uo_out}, 32'hF0);
    check("invalid_uio_out", {24'd0, pads.uio_out}, 32'h01);

    // 50% PWM on channel 0
    spi_frame(32'h8001, 16, 1);
    spi_frame(32'h8100, 16, 1);
    spi_frame(32'h8201, 16, 1);
    spi_frame(32'h8480, 16, 1);
    wait_level(1'b0, n0, t0);
    wait_level(1'b1, n0, t0);
    wait_level(1'b0, n1, t1);
    wait_level(1'b1, n2, t2);
    check_range("pwm_period_clk", n2 - n0, 3327, 3329);
    check_range("pwm_high_clk", n1 - n0, 1664, 1664);
    check_range("pwm_freq_hz", (t2 > t0) ? int'(1.0e9 / (t2 - t0)) : 0, 2970, 3030);

    // Duty limits
    spi_frame(32'h8400, 16, 1);
    cnt = 0;
    for (int i = 0; i < 2 * 3328 + 20; i++) begin
      if (pads.uo_out[0]) cnt++;
      clocks(1);
    end
    check("duty00_high_cycles", cnt, 0);
    spi_frame(32'h84FF, 16, 1);
    cnt = 0;
    for (int i = 0; i < 2 * 3328 + 20; i++) begin
      if (!pads.uo_out[0]) cnt++;
      clocks(1);
    end
    check("dutyFF_low_cycles", cnt, 0);

    // Randomized frames against the model
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      pads.uio_in = 8'($urandom);
      pads.ena    = 1'($urandom);
      w  = $urandom;
      nb = 16;
      if (kind <= 5) begin
        w = {16'd0, 1'b1, 4'd0, 3'($urandom_range(0, 4)), 8'($urandom)};
      end else if (kind == 6) begin
        w[15] = 1'b0;
      end else if (kind == 7) begin
        w = {16'd0, 1'b1, 7'($urandom_range(5, 127)), 8'($urandom)};
      end else if (kind == 8) begin
        nb = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 15) : $urandom_range(17, 20);
      end
      if (kind == 9) begin
        for (int p = 0; p < 5; p++) begin
          pads.ui_in[1] = 1'($urandom);
          pads.ui_in[0] = 1'b1;
          clocks(4);
          pads.ui_in[0] = 1'b0;
          clocks(4);
        end
      end else begin
        spi_frame(w, nb, 1);
      end
      clocks($urandom_range(0, 60));
    end
    clocks(3400);

    // Mid-frame reset aborts the write; the next frame commits
    spi_frame(32'h0080, 8, 0);
    rst = 1'b1;
    m_en_out = '0;
    m_en_pwm = '0;
    m_duty   = '0;
    mark_n   = -100;
    clocks(5);
    rst = 1'b0;
    clocks(2);
    pads.ui_in[2] = 1'b1;
    clocks(12);
    check("midreset_uo_out", {24'd0, pads.uo_out}, 32'h00);
    spi_frame(32'h80FF, 16, 1);
    check("after_reset_commit", {24'd0, pads.uo_out}, 32'hFF);
    clocks(20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uwasic_spi_pwm_periph.md
Name: uwasic_spi_pwm_periph

Overview:
- Tiny Tapeout user tile: an SPI write-only peripheral programs five 8-bit control registers.
- The registers gate 16 outputs (uo_out[7:0], uio_out[7:0]) to static high, low, or a shared ~3 kHz PWM waveform.
- Sits at the top of the user tile, fed directly by the chip pads.

Parameters:
- PWM_PRESCALE, 13, clk cycles per PWM phase step. The 8-bit phase gives a period of PWM_PRESCALE*256 clks (about 3.0 kHz at 10 MHz).
- NUM_REGS, 5, number of valid register addresses (0x00..NUM_REGS-1).

Ports:
- clk  in  1  system clock, 10 MHz nominal
- rst  in  1  synchronous active-high reset
- ena  in  1  tile enable, ignored
- ui_in  in  8  [0]=SCLK, [1]=COPI, [2]=nCS, [7:3] unused
- uio_in  in  8  unused
- uo_out  out  8  output channels 7..0
- uio_out  out  8  output channels 15..8
- uio_oe  out  8  constant 8'hFF

Behaviour:
- Interface: one clock; reset is synchronous and active-high. On rst=1 at a clk rising edge, all registers, synchronizers, the SPI shift state and the PWM counters clear to 0; uo_out=uio_out=0.
- Synchronization: SCLK, COPI and nCS each pass through a 2-FF synchronizer on clk. Edges are detected from the synchronized copies, so minimum SCLK half-period is 3 clk.
- SPI format: mode 0, MSB first, 16 bits per frame.
  - bit15 = R/W (1=write), bits14:8 = 7-bit address, bits7:0 = data.
  - COPI is sampled on each synchronized SCLK rising edge while nCS is low.
  - nCS falling edge clears the bit counter and shift register.
- Commit: on the synchronized nCS rising edge, the register is written one clk after the edge is detected, only if all of these hold:
  - exactly 16 bits were received;
  - R/W=1;
  - address < NUM_REGS.
- Ignored frames: reads (R/W=0), bad addresses, and frames with a bit count other than 16 (short or long) are discarded and leave no state change. SCLK edges while nCS is high are ignored.
- Reset mid-frame: the frame is aborted and nothing is written.
- Register map (all reset to 0x00):
  - 0x00 en_out[7:0]
  - 0x01 en_out[15:8]
  - 0x02 en_pwm[7:0]
  - 0x03 en_pwm[15:8]
  - 0x04 duty
- Output channel i (uo_out bits for i=0..7, uio_out bits for i=8..15): out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0.
- PWM generation:
  - A prescaler counts 0..PWM_PRESCALE-1; on wrap, the 8-bit phase increments and wraps 255 to 0.
  - pwm = 1 when duty==0xFF, otherwise (phase < duty).
  - duty=0x00 gives constant low; duty=0x80 gives 50%.
  - All channels share one phase.
- Outputs are registered, so a change reaches the pins 1 clk after the register or phase update.

Optional Feature:
- Macro: PWM_ALIGN_EN.
- Defined: a write to duty lands in a shadow register. The active duty loads only when phase wraps 255 to 0, giving glitch-free periods.
- Undefined: the duty write takes effect immediately.

Test Plan:
- Reset: rst=1 for 5 clk, then 0 -> uo_out=0x00, uio_out=0x00, uio_oe=0xFF.
- Static outputs: write 0x80F0 (addr0=0xF0), then 0x8101 (addr1=0x01) -> uo_out=0xF0, uio_out=0x01 and remain stable.
- Invalid frames: read frame 0x00AA; write to addr 0x30 (frame 0xB0FF); a 15-bit frame -> no register changes, outputs unchanged.
- PWM 50%: en_out[0]=1, en_pwm[0]=1, duty=0x80 -> uo_out[0] period 3328 clk ±1, high 1664 clk, measured frequency 3000 Hz ±1%.
- Duty limits: duty=0x00 -> uo_out[0] low for ≥2 periods; duty=0xFF -> uo_out[0] high for ≥2 periods.
- Mid-frame reset: assert rst after 8 bits of a write to addr0 (frame 0x80FF) -> no write; the next full frame commits normally.
